if_stage: RTL and testbench
===========================

// Module: if_stage
// PURPOSE
//   Instruction-fetch stage. Owns the PC and a small writable instruction memory.
//   Registers {instr, nextInstr, nextPC} every cycle for the IF/ID pipeline register downstream.
//   Supports a stall from hazard detection and a redirect (taken branch/jump) that flushes the slot.
// PARAMETERS
//   PC_W     4             PC width; memory depth = 2**PC_W words
//   INSTR_W  32            instruction width
//   NOP      32'h00000000  bubble word driven on reset/flush
// PORTS
//   clk          in   1        rising-edge clock
//   rst          in   1        synchronous, active-high reset
//   stall        in   1        hold PC and outputs this cycle
//   redirect     in   1        load redirect_pc, flush fetch slot
//   redirect_pc  in   PC_W     redirect target
//   imem_we      in   1        instruction-memory write enable
//   imem_waddr   in   PC_W     write address
//   imem_wdata   in   INSTR_W  write data
//   pc           out  PC_W     address of instr currently presented
//   instr        out  INSTR_W  mem[pc] as fetched
//   nextInstr    out  INSTR_W  mem[pc+1] (wraps) as fetched
//   nextPC       out  PC_W     pc+1 mod 2**PC_W
//   valid        out  1        outputs hold a real fetch (0 = bubble)
// BEHAVIOUR
//   - Internal fetch pointer fpc (PC_W bits); memory 2**PC_W x INSTR_W, async read, sync write.
//   - All outputs registered; update on rising clk only. Latency: fpc -> outputs = 1 cycle.
//   - Priority per cycle: rst > redirect > stall > normal fetch.
//   - rst: fpc<=0; pc<=0; instr<=NOP; nextInstr<=NOP; nextPC<=0; valid<=0. Memory not cleared.
//   - redirect: fpc<=redirect_pc; instr<=NOP; nextInstr<=NOP; valid<=0; pc, nextPC hold.
//     Fetch from redirect_pc appears on outputs the cycle after next (1 bubble).
//   - stall (no redirect): fpc and all outputs hold, including valid.
//   - normal: pc<=fpc; instr<=mem[fpc]; nextInstr<=mem[fpc+1]; nextPC<=fpc+1; valid<=1;
//     fpc<=fpc+1.
//   - Wrap: fpc=2**PC_W-1 -> nextPC=0, nextInstr=mem[0], fpc<=0. No overflow flag.
//   - Memory write: mem[imem_waddr]<=imem_wdata at the edge, regardless of rst/stall/redirect.
//     Same-cycle read of that address returns OLD data; new data visible from the next fetch.
//   - Mode FSM (observable through valid/pc): RESET -> FETCH on first cycle with rst=0;
//     FETCH -stall-> HOLD, HOLD -!stall-> FETCH; any -redirect-> FLUSH -> FETCH next cycle
//     (or HOLD if stall); rst from any state -> RESET.
//     RESET, FLUSH: valid=0. FETCH: valid=1. HOLD: valid unchanged.
//   - Reset mid-stall or mid-flush: fully re-initialises next edge; stall/redirect ignored.
// TESTING
//   1 Reset: preload mem[0..3]=A0..A3; rst=1 two cycles -> valid=0, instr=NOP, nextPC=0, pc=0.
//   2 Sequential: release rst -> cycle1: pc=0, instr=A0, nextInstr=A1, nextPC=1, valid=1;
//     cycle2: pc=1, instr=A1.
//   3 Stall: stall=1 for 3 cycles at pc=2 -> outputs frozen at pc=2/A2/A3/3;
//     drop stall -> next pc=3.
//   4 Redirect: redirect=1, redirect_pc=9 -> next cycle valid=0, instr=NOP;
//     following cycle pc=9, instr=mem[9], nextPC=10.
//   5 Wrap: redirect to 15 -> outputs pc=15, nextInstr=mem[0], nextPC=0; next pc=0.
//   6 Write/read collision: write mem[5]=DEAD while fetching 5 -> instr=old mem[5];
//     redirect to 5 -> instr=DEAD. Redirect+stall same cycle -> redirect wins.

Source files
------------

// File: rtl/if_stage.sv
// -----------------------------------------------------------------------------
// if_stage -- instruction-fetch stage with a small writable instruction memory.
//
// Owns the fetch pointer (fpc) and presents a registered fetch slot
// {pc, instr, nextInstr, nextPC, valid} to the IF/ID register downstream.
// Priority per cycle: rst > redirect > stall > normal fetch.
//
// Ports
//   clk, rst                  rising-edge clock, synchronous active-high reset
//   stall                     hold fpc and all outputs
//   redirect, redirect_pc     load new fetch pointer, flush the slot (1 bubble)
//   imem_we/waddr/wdata       synchronous memory write (always honoured)
//   pc, instr, nextInstr,     registered fetch slot; nextInstr/nextPC wrap
//   nextPC, valid             modulo 2**PC_W; valid=0 marks a bubble
// -----------------------------------------------------------------------------
module if_stage #(
  parameter int                 PC_W    = 4,
  parameter int                 INSTR_W = 32,
  parameter logic [INSTR_W-1:0] NOP     = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc,
  input  logic               imem_we,
  input  logic [PC_W-1:0]    imem_waddr,
  input  logic [INSTR_W-1:0] imem_wdata,
  output logic [PC_W-1:0]    pc,
  output logic [INSTR_W-1:0] instr,
  output logic [INSTR_W-1:0] nextInstr,
  output logic [PC_W-1:0]    nextPC,
  output logic               valid
);

  localparam int DEPTH = 2 ** PC_W;

  // Bit 0 of the state is the valid flag itself, so valid comes straight off
  // a flop. HOLD is split in two so a stall preserves whichever valid it froze.
  typedef enum logic [2:0] {
    S_RESET      = 3'b000,
    S_FLUSH      = 3'b010,
    S_FETCH      = 3'b001,
    S_HOLD_IDLE  = 3'b100,
    S_HOLD_VALID = 3'b101
  } mode_t;

  mode_t               state;
  logic [PC_W-1:0]     fpc;
  logic [PC_W-1:0]     fpc_inc;
  logic [INSTR_W-1:0]  mem [DEPTH];

  assign fpc_inc = fpc + 1'b1;   // wraps naturally at 2**PC_W
  assign valid   = state[0];

  // Write port: independent of rst/stall/redirect. Reads below are async, so a
  // same-edge read of the written address still sees the old word.
  always_ff @(posedge clk) begin
    if (imem_we) mem[imem_waddr] <= imem_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_RESET;
      fpc       <= '0;
      pc        <= '0;
      instr     <= NOP;
      nextInstr <= NOP;
      nextPC    <= '0;
    end else if (redirect) begin
      // pc/nextPC keep their last values; only the payload is squashed.
      state     <= S_FLUSH;
      fpc       <= redirect_pc;
      instr     <= NOP;
      nextInstr <= NOP;
    end else if (stall) begin
      state     <= state[0] ? S_HOLD_VALID : S_HOLD_IDLE;
    end else begin
      state     <= S_FETCH;
      pc        <= fpc;
      instr     <= mem[fpc];
      nextInstr <= mem[fpc_inc];
      nextPC    <= fpc_inc;
      fpc       <= fpc_inc;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

  localparam int PC_W    = 4;
  localparam int INSTR_W = 32;
  localparam int DEPTH   = 16;

  logic               clk = 1'b0;
  logic               rst, stall, redirect, imem_we;
  logic [PC_W-1:0]    redirect_pc, imem_waddr;
  logic [INSTR_W-1:0] imem_wdata;
  logic [PC_W-1:0]    pc, nextPC;
  logic [INSTR_W-1:0] instr, nextInstr;
  logic               valid;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [31:0] m_mem [DEPTH];
  int          m_fpc, m_pc, m_npc;
  logic [31:0] m_instr, m_ni;
  logic        m_valid;

  if_stage #(.PC_W(PC_W), .INSTR_W(INSTR_W), .NOP(32'h0)) dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_we(imem_we), .imem_waddr(imem_waddr),
    .imem_wdata(imem_wdata), .pc(pc), .instr(instr), .nextInstr(nextInstr),
    .nextPC(nextPC), .valid(valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, advance model, sample DUT 1ns after the edge.
  task automatic step(input bit r, input bit s, input bit rd, input int rpc,
                      input bit we, input int wa, input logic [31:0] wd);
    @(negedge clk);
    rst = r; stall = s; redirect = rd; redirect_pc = rpc[PC_W-1:0];
    imem_we = we; imem_waddr = wa[PC_W-1:0]; imem_wdata = wd;
    if (r) begin
      m_fpc = 0; m_pc = 0; m_npc = 0; m_instr = 0; m_ni = 0; m_valid = 0;
    end else if (rd) begin
      m_fpc = rpc % DEPTH; m_instr = 0; m_ni = 0; m_valid = 0;
    end else if (!s) begin
      m_pc = m_fpc; m_instr = m_mem[m_fpc]; m_ni = m_mem[(m_fpc + 1) % DEPTH];
      m_npc = (m_fpc + 1) % DEPTH; m_valid = 1; m_fpc = (m_fpc + 1) % DEPTH;
    end
    if (we) m_mem[wa % DEPTH] = wd;
    @(posedge clk); #1;
    chk("pc",        64'(pc),        64'(m_pc));
    chk("instr",     64'(instr),     64'(m_instr));
    chk("nextInstr", 64'(nextInstr), 64'(m_ni));
    chk("nextPC",    64'(nextPC),    64'(m_npc));
    chk("valid",     64'(valid),     64'(m_valid));
  endtask

  task automatic run(input bit s);  // plain cycle, optional stall
    step(0, s, 0, 0, 0, 0, 32'h0);
  endtask

  initial begin
    rst = 1; stall = 0; redirect = 0; redirect_pc = '0;
    imem_we = 0; imem_waddr = '0; imem_wdata = '0;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'hx;

    // 1: preload A0..A15 while held in reset
    for (int i = 0; i < DEPTH; i++) step(1, 0, 0, 0, 1, i, 32'hA000_0000 + i);
    step(1, 0, 0, 0, 0, 0, 32'h0);
    step(1, 0, 0, 0, 0, 0, 32'h0);
    chk("rst_valid", 64'(valid), 64'd0);
    chk("rst_instr", 64'(instr), 64'd0);
    chk("rst_pc",    64'(pc),    64'd0);
    chk("rst_npc",   64'(nextPC), 64'd0);

    // 2: sequential fetch
    run(0);
    chk("seq_pc0",  64'(pc),        64'd0);
    chk("seq_i0",   64'(instr),     64'hA000_0000);
    chk("seq_ni0",  64'(nextInstr), 64'hA000_0001);
    chk("seq_npc0", 64'(nextPC),    64'd1);
    chk("seq_v0",   64'(valid),     64'd1);
    run(0);
    chk("seq_pc1", 64'(pc),    64'd1);
    chk("seq_i1",  64'(instr), 64'hA000_0001);

    // 3: stall at pc=2
    run(0);
    for (int k = 0; k < 3; k++) begin
      run(1);
      chk("stall_pc",  64'(pc),        64'd2);
      chk("stall_i",   64'(instr),     64'hA000_0002);
      chk("stall_ni",  64'(nextInstr), 64'hA000_0003);
      chk("stall_npc", 64'(nextPC),    64'd3);
      chk("stall_v",   64'(valid),     64'd1);
    end
    run(0);
    chk("unstall_pc", 64'(pc), 64'd3);

    // 4: redirect to 9
    step(0, 0, 1, 9, 0, 0, 32'h0);
    chk("redir_v", 64'(valid), 64'd0);
    chk("redir_i", 64'(instr), 64'd0);
    run(0);
    chk("redir_pc",  64'(pc),     64'd9);
    chk("redir_i9",  64'(instr),  64'hA000_0009);
    chk("redir_npc", 64'(nextPC), 64'd10);

    // 5: wrap
    step(0, 0, 1, 15, 0, 0, 32'h0);
    run(0);
    chk("wrap_pc",  64'(pc),        64'd15);
    chk("wrap_ni",  64'(nextInstr), 64'hA000_0000);
    chk("wrap_npc", 64'(nextPC),    64'd0);
    run(0);
    chk("wrap_next", 64'(pc), 64'd0);

    // 6: write/read collision, then redirect+stall (redirect wins)
    step(0, 0, 1, 4, 0, 0, 32'h0);
    run(0);                                    // pc=4, fpc=5
    step(0, 0, 0, 0, 1, 5, 32'h0000_DEAD);     // fetch 5 while writing 5
    chk("coll_pc",  64'(pc),    64'd5);
    chk("coll_old", 64'(instr), 64'hA000_0005);
    step(0, 1, 1, 5, 0, 0, 32'h0);
    chk("rs_v", 64'(valid), 64'd0);
    run(0);
    chk("coll_pc2", 64'(pc),    64'd5);
    chk("coll_new", 64'(instr), 64'h0000_DEAD);

    // reset mid-stall
    run(1);
    step(1, 1, 1, 7, 0, 0, 32'h0);
    chk("rst_stall_v",  64'(valid), 64'd0);
    chk("rst_stall_pc", 64'(pc),    64'd0);
    run(0);
    chk("after_rst_pc", 64'(pc), 64'd0);

    // randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      step($urandom_range(39) == 0, $urandom_range(3) == 0, $urandom_range(5) == 0,
           int'($urandom_range(DEPTH - 1)), $urandom_range(2) == 0,
           int'($urandom_range(DEPTH - 1)), $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
